// File: rtl/sr_enc_pkg.sv
// sr_enc_pkg: shared definitions for the RV32I instruction encoder.
//   - sr_enc_op_t : symbolic mnemonic carried on in_op (6 bits)
//   - RVOP_* / RVF3_* / RVF7_* : opcode, funct3, funct7 field values
//   - encode_word() : mnemonic + operands -> 32-bit instruction word
// Optional macro SR_ENC_RANGE_CHECK_EN: when defined, encode_word() rejects
// immediates that do not fit their field instead of truncating them.
package sr_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
        OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
        OP_OR    = 6'd8,  OP_AND   = 6'd9,
        OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13,
        OP_ORI   = 6'd14, OP_ANDI  = 6'd15, OP_SLLI  = 6'd16, OP_SRLI  = 6'd17,
        OP_SRAI  = 6'd18,
        OP_LUI   = 6'd19, OP_AUIPC = 6'd20,
        OP_BEQ   = 6'd21, OP_BNE   = 6'd22, OP_BLT   = 6'd23, OP_BGE   = 6'd24,
        OP_BLTU  = 6'd25, OP_BGEU  = 6'd26,
        OP_JAL   = 6'd27, OP_JALR  = 6'd28
    } sr_enc_op_t;

    localparam logic [6:0] RVOP_LUI    = 7'b0110111;
    localparam logic [6:0] RVOP_AUIPC  = 7'b0010111;
    localparam logic [6:0] RVOP_JAL    = 7'b1101111;
    localparam logic [6:0] RVOP_JALR   = 7'b1100111;
    localparam logic [6:0] RVOP_BRANCH = 7'b1100011;
    localparam logic [6:0] RVOP_OP_IMM = 7'b0010011;
    localparam logic [6:0] RVOP_OP     = 7'b0110011;

    localparam logic [2:0] RVF3_ADD_SUB = 3'b000;
    localparam logic [2:0] RVF3_SLL     = 3'b001;
    localparam logic [2:0] RVF3_SLT     = 3'b010;
    localparam logic [2:0] RVF3_SLTU    = 3'b011;
    localparam logic [2:0] RVF3_XOR     = 3'b100;
    localparam logic [2:0] RVF3_SRL_SRA = 3'b101;
    localparam logic [2:0] RVF3_OR      = 3'b110;
    localparam logic [2:0] RVF3_AND     = 3'b111;
    localparam logic [2:0] RVF3_BEQ     = 3'b000;
    localparam logic [2:0] RVF3_BNE     = 3'b001;
    localparam logic [2:0] RVF3_BLT     = 3'b100;
    localparam logic [2:0] RVF3_BGE     = 3'b101;
    localparam logic [2:0] RVF3_BLTU    = 3'b110;
    localparam logic [2:0] RVF3_BGEU    = 3'b111;
    localparam logic [2:0] RVF3_JALR    = 3'b000;

    localparam logic [6:0] RVF7_BASE = 7'h00;
    localparam logic [6:0] RVF7_ALT  = 7'h20;  // SUB, SRA, SRAI

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_U, FMT_B, FMT_J, FMT_BAD
    } sr_enc_fmt_t;

    typedef struct packed {
        logic        ok;    // 0: unknown op (or out-of-range immediate)
        logic [31:0] word;
    } sr_enc_result_t;

    function automatic sr_enc_result_t encode_word(
        input logic [5:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        sr_enc_fmt_t    fmt;
        logic [6:0]     opc;
        logic [2:0]     f3;
        logic [6:0]     f7;
        sr_enc_result_t res;
`ifdef SR_ENC_RANGE_CHECK_EN
        logic signed [31:0] simm;
`endif
        fmt      = FMT_BAD;
        opc      = RVOP_OP;
        f3       = RVF3_ADD_SUB;
        f7       = RVF7_BASE;
        res.ok   = 1'b1;
        res.word = '0;

        case (sr_enc_op_t'(op))
            OP_ADD:   begin fmt = FMT_R;  f3 = RVF3_ADD_SUB; end
            OP_SUB:   begin fmt = FMT_R;  f3 = RVF3_ADD_SUB; f7 = RVF7_ALT; end
            OP_SLL:   begin fmt = FMT_R;  f3 = RVF3_SLL;  end
            OP_SLT:   begin fmt = FMT_R;  f3 = RVF3_SLT;  end
            OP_SLTU:  begin fmt = FMT_R;  f3 = RVF3_SLTU; end
            OP_XOR:   begin fmt = FMT_R;  f3 = RVF3_XOR;  end
            OP_SRL:   begin fmt = FMT_R;  f3 = RVF3_SRL_SRA; end
            OP_SRA:   begin fmt = FMT_R;  f3 = RVF3_SRL_SRA; f7 = RVF7_ALT; end
            OP_OR:    begin fmt = FMT_R;  f3 = RVF3_OR;   end
            OP_AND:   begin fmt = FMT_R;  f3 = RVF3_AND;  end
            OP_ADDI:  begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_ADD_SUB; end
            OP_SLTI:  begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_SLTU; end
            OP_XORI:  begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_XOR;  end
            OP_ORI:   begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_OR;   end
            OP_ANDI:  begin fmt = FMT_I;  opc = RVOP_OP_IMM; f3 = RVF3_AND;  end
            OP_SLLI:  begin fmt = FMT_SH; opc = RVOP_OP_IMM; f3 = RVF3_SLL;  end
            OP_SRLI:  begin fmt = FMT_SH; opc = RVOP_OP_IMM; f3 = RVF3_SRL_SRA; end
            OP_SRAI:  begin fmt = FMT_SH; opc = RVOP_OP_IMM; f3 = RVF3_SRL_SRA; f7 = RVF7_ALT; end
            OP_LUI:   begin fmt = FMT_U;  opc = RVOP_LUI;   end
            OP_AUIPC: begin fmt = FMT_U;  opc = RVOP_AUIPC; end
            OP_BEQ:   begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BNE;  end
            OP_BLT:   begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BLT;  end
            OP_BGE:   begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BGE;  end
            OP_BLTU:  begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B;  opc = RVOP_BRANCH; f3 = RVF3_BGEU; end
            OP_JAL:   begin fmt = FMT_J;  opc = RVOP_JAL;   end
            OP_JALR:  begin fmt = FMT_I;  opc = RVOP_JALR;  f3 = RVF3_JALR; end
            default:  fmt = FMT_BAD;
        endcase

        case (fmt)
            FMT_R:   res.word = {f7, rs2, rs1, f3, rd, opc};
            FMT_I:   res.word = {imm[11:0], rs1, f3, rd, opc};
            FMT_SH:  res.word = {f7, imm[4:0], rs1, f3, rd, opc};
            FMT_U:   res.word = {imm[31:12], rd, opc};
            FMT_B:   res.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_J:   res.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: res.ok = 1'b0;
        endcase

`ifdef SR_ENC_RANGE_CHECK_EN
        simm = imm;
        case (fmt)
            FMT_I:   if (simm < -2048 || simm > 2047) res.ok = 1'b0;
            FMT_SH:  if (imm > 32'd31) res.ok = 1'b0;
            FMT_U:   if (imm[11:0] != 12'd0) res.ok = 1'b0;
            FMT_B:   if (simm < -4096 || simm > 4094 || imm[0]) res.ok = 1'b0;
            FMT_J:   if (simm < -1048576 || simm > 1048574 || imm[0]) res.ok = 1'b0;
            default: ;
        endcase
`endif

        if (!res.ok) res.word = '0;
        return res;
    endfunction

endpackage

// File: rtl/sr_instr_encoder_fifo.sv
// sr_enc_fifo: DEPTH-entry synchronous FIFO of W-bit entries.
//   clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// Push while full and pop while empty are ignored. Flags derive only from
// registered pointers, so they are safe to use for upstream ready signals.
module sr_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [W-1:0]   mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[PTR_W], rd_ptr[PTR_W-1:0]});
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and the top gates dout while empty.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/sr_instr_encoder.sv
// sr_instr_encoder: encodes symbolic RV32I operations into instruction words,
// queues them and emits each with its sequential word address.
//   clk, rst           : clock, synchronous active-high reset
//   start              : pulse in IDLE -> clear address, enter RUN
//   in_valid/in_ready  : operation handshake (in_op, in_rd, in_rs1, in_rs2,
//                        in_imm, in_last)
//   out_valid/out_ready: word handshake (out_word, out_addr)
//   done               : one-cycle pulse when the program has fully drained
//   err                : one-cycle pulse, the cycle after an invalid op is accepted
// Optional macro SR_ENC_RANGE_CHECK_EN enables immediate range checking.
module sr_instr_encoder
    import sr_enc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic                err_q;
    logic                accept;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ADDR_W+31:0]  fifo_dout;
    sr_enc_result_t      enc;

    assign enc       = encode_word(in_op, in_rd, in_rs1, in_rs2, in_imm);
    assign in_ready  = (state == ST_RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc.ok;

    assign out_valid = !fifo_empty;
    assign out_word  = fifo_empty ? 32'd0 : fifo_dout[31:0];
    assign out_addr  = fifo_empty ? '0 : fifo_dout[ADDR_W+31:32];
    assign done      = (state == ST_DRAIN) && fifo_empty;
    assign err       = err_q;

    // Each entry carries the address it will have when it leaves the queue:
    // the number of words ahead of it since start, i.e. its push index.
    sr_enc_fifo #(.DEPTH(DEPTH), .W(ADDR_W + 32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({addr_q, enc.word}),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && !enc.ok;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) addr_q <= addr_q + 1'b1;
                    // A rejected op still completes the handshake, so a
                    // rejected final op still ends the program.
                    if (accept && in_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_instr_encoder.sv
module tb_sr_instr_encoder;
    import sr_enc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    sr_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one op and hold it until accepted (bounded wait).
    task automatic send_op(input logic [5:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic last);
        int waited;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_op_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count done pulses over a bounded window; exactly one is required.
    task automatic wait_done(input string name);
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, pulses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: {in_ready,out_valid,done,err}=%b, required 0000",
                     {in_ready, out_valid, done, err});
        end
        checks++;
        if (out_word !== 32'd0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: word=%h addr=%0d, required 0 and 0", out_word, out_addr);
        end
    endtask

    task automatic test_add();
        do_start();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_run_ready: in_ready=%0b, required 1", in_ready);
        end
        out_ready = 1'b1;
        send_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h002081B3 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL add_word: valid=%0b word=%h addr=%0d, required 1 002081b3 0",
                     out_valid, out_word, out_addr);
        end
        wait_done("add");
    endtask

    task automatic test_imm_shift();
        do_start();
        out_ready = 1'b1;
        send_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        checks++;
        if (out_word !== 32'h00500093 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL addi_word: word=%h addr=%0d, required 00500093 0", out_word, out_addr);
        end
        send_op(OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1);
        checks++;
        if (out_word !== 32'h4030D093 || out_addr !== 8'd1) begin
            errors++;
            $display("FAIL srai_word: word=%h addr=%0d, required 4030d093 1", out_word, out_addr);
        end
        wait_done("imm_shift");
    endtask

    task automatic test_program();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h123452B7;
        exp_w[1] = 32'h00208463;
        exp_w[2] = 32'h010000EF;
        do_start();
        out_ready = 1'b0;
        send_op(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
        send_op(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send_op(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== exp_w[i] || out_addr !== 8'(i) || done !== 1'b0) begin
                errors++;
                $display("FAIL program_word%0d: valid=%0b word=%h addr=%0d done=%0b, required 1 %h %0d 0",
                         i, out_valid, out_word, out_addr, done, exp_w[i], i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL program_done: done=%0b after third pop, required 1", done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL program_done_once: done=%0b, required 0", done);
        end
    endtask

    task automatic test_back_to_back_full();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00100093;
        exp_w[1] = 32'h00200113;
        exp_w[2] = 32'h00300193;
        exp_w[3] = 32'h00400213;
        do_start();
        out_ready = 1'b0;
        send_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        send_op(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
        // start during RUN must not clear the address counter
        do_start();
        send_op(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0);
        send_op(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_low: in_ready=%0b, required 0", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== exp_w[i] || out_addr !== 8'(i)) begin
                errors++;
                $display("FAIL full_word%0d: valid=%0b word=%h addr=%0d, required 1 %h %0d",
                         i, out_valid, out_word, out_addr, exp_w[i], i);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready_back: in_ready=%0b, required 1", in_ready);
                end
            end
        end
        send_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        checks++;
        if (out_word !== 32'h002081B3 || out_addr !== 8'd4) begin
            errors++;
            $display("FAIL full_tail: word=%h addr=%0d, required 002081b3 4", out_word, out_addr);
        end
        wait_done("full");
    endtask

    task automatic test_err();
        logic [ADDR_W-1:0] tail_addr;
        do_start();
        out_ready = 1'b1;
        send_op(6'd63, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unknown_op: err=%0b out_valid=%0b, required 1 0", err, out_valid);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL unknown_op_pulse: err=%0b one cycle later, required 0", err);
        end
`ifdef SR_ENC_RANGE_CHECK_EN
        send_op(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_range: err=%0b out_valid=%0b, required 1 0", err, out_valid);
        end
        send_op(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL beq_odd: err=%0b out_valid=%0b, required 1 0", err, out_valid);
        end
        tail_addr = 8'd0;
`else
        send_op(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0);
        checks++;
        if (err !== 1'b0 || out_word !== 32'h80000013 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL addi_trunc: err=%0b word=%h addr=%0d, required 0 80000013 0",
                     err, out_word, out_addr);
        end
        tail_addr = 8'd1;
`endif
        tick();
        send_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        checks++;
        if (out_word !== 32'h002081B3 || out_addr !== tail_addr) begin
            errors++;
            $display("FAIL err_tail: word=%h addr=%0d, required 002081b3 %0d",
                     out_word, out_addr, tail_addr);
        end
        wait_done("err");
    endtask

    task automatic test_rst_drain();
        int pulses = 0;
        do_start();
        out_ready = 1'b0;
        send_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send_op(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 8'd0 || out_word !== 32'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain: valid=%0b addr=%0d word=%h ready=%0b, required 0 0 0 0",
                     out_valid, out_addr, out_word, in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rst_drain_done: %0d done pulses, required 0", pulses);
        end
        do_start();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: in_ready=%0b after start, required 1", in_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_add();
        test_imm_shift();
        test_program();
        test_back_to_back_full();
        test_err();
        test_rst_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
